// File: rtl/minmax_tracker_pkg.sv
// Shared types for the frame min/max tracker: FSM encoding, default width and
// the comparator result bundle.
package minmax_tracker_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Comparator result ordering {eq, gt, lt}; exactly one bit is set.
    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_t;

endpackage

// File: rtl/minmax_tracker_mag_compare.sv
// Unsigned magnitude comparator: compares a_i against b_i, one-hot eq/gt/lt.
module mag_compare
    import minmax_tracker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);

endmodule

// File: rtl/minmax_tracker.sv
// Per-frame running max/min/first-max-index over N samples, presented as one
// result per frame through a valid/ready handshake.
module minmax_tracker
    import minmax_tracker_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [IDX_W-1:0] out_max_idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cmp_t             cmp_max, cmp_min;
    logic             accept;

    mag_compare #(.WIDTH(WIDTH)) u_cmp_max (
        .a_i (in_data),
        .b_i (max_q),
        .eq_o(cmp_max.eq),
        .gt_o(cmp_max.gt),
        .lt_o(cmp_max.lt)
    );

    mag_compare #(.WIDTH(WIDTH)) u_cmp_min (
        .a_i (in_data),
        .b_i (min_q),
        .eq_o(cmp_min.eq),
        .gt_o(cmp_min.gt),
        .lt_o(cmp_min.lt)
    );

    // Handshake outputs decode from state only, so no valid->ready paths.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        min_d   = min_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (cnt_q == '0) begin
                        max_d = in_data;
                        min_d = in_data;
                        idx_d = '0;
                    end else begin
                        // Ties keep the stored value, so the earliest index wins.
                        unique case (1'b1)
                            cmp_max.gt: begin
                                max_d = in_data;
                                idx_d = cnt_q;
                            end
                            cmp_max.eq, cmp_max.lt: ;
                        endcase
                        unique case (1'b1)
                            cmp_min.lt: min_d = in_data;
                            cmp_min.eq, cmp_min.gt: ;
                        endcase
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            max_q   <= '0;
            min_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
        end
    end

    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = idx_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// Bench for minmax_tracker: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_minmax_tracker;

    localparam int WIDTH = 4;
    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_max;
    logic [WIDTH-1:0] out_min;
    logic [IDX_W-1:0] out_max_idx;

    int checks = 0;
    int errors = 0;

    minmax_tracker #(.WIDTH(WIDTH), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_min    (out_min),
        .out_max_idx(out_max_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: samples of the current frame kept in a queue; the
    // visible statistics are recomputed from the whole queue on every accept.
    bit m_known = 1'b0;
    bit m_hold  = 1'b0;
    int m_q[$];
    int m_max = 0, m_min = 0, m_idx = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                chk("mon_in_ready",  in_ready,    !m_hold);
                chk("mon_out_valid", out_valid,   m_hold);
                chk("mon_out_max",   out_max,     m_max);
                chk("mon_out_min",   out_min,     m_min);
                chk("mon_out_idx",   out_max_idx, m_idx);
            end
            if (rst) begin
                m_known = 1'b1;
                m_hold  = 1'b0;
                m_q.delete();
                m_max = 0; m_min = 0; m_idx = 0;
            end else if (m_known) begin
                if (!m_hold && in_valid) begin
                    m_q.push_back(int'(in_data));
                    m_max = m_q[0];
                    m_min = m_q[0];
                    foreach (m_q[i]) begin
                        if (m_q[i] > m_max) m_max = m_q[i];
                        if (m_q[i] < m_min) m_min = m_q[i];
                    end
                    m_idx = -1;
                    foreach (m_q[i]) if (m_idx < 0 && m_q[i] == m_max) m_idx = i;
                    if (m_q.size() == N) begin
                        m_hold = 1'b1;
                        m_q.delete();
                    end
                end else if (m_hold && out_ready) begin
                    m_hold = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and return once it has been accepted.
    task automatic send(input int d);
        bit ok;
        int budget;
        budget   = 20;
        in_valid = 1'b1;
        in_data  = d[WIDTH-1:0];
        do begin
            ok = in_ready;
            tick();
            budget--;
        end while (!ok && budget > 0);
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic handoff();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic expect_res(input string tag, input int mx, input int mn, input int ix);
        chk({tag, "_valid"}, out_valid,   32'd1);
        chk({tag, "_ready"}, in_ready,    32'd0);
        chk({tag, "_max"},   out_max,     mx);
        chk({tag, "_min"},   out_min,     mn);
        chk({tag, "_idx"},   out_max_idx, ix);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", out_valid,   32'd0);
        chk("rst_ready", in_ready,    32'd1);
        chk("rst_max",   out_max,     32'd0);
        chk("rst_min",   out_min,     32'd0);
        chk("rst_idx",   out_max_idx, 32'd0);

        // Back-to-back frame held by downstream
        send(3); send(9); send(1); send(7);
        in_valid = 1'b0;
        expect_res("s2", 9, 1, 1);

        // HOLD ignores upstream traffic
        in_valid = 1'b1;
        in_data  = 4'd2;
        repeat (3) tick();
        expect_res("s4_hold", 9, 1, 1);
        handoff();
        chk("s4_post_valid", out_valid, 32'd0);
        chk("s4_post_ready", in_ready,  32'd1);
        send(2); send(2); send(2); send(2);
        in_valid = 1'b0;
        expect_res("s4_frame", 2, 2, 0);
        handoff();

        // All-equal frame keeps the earliest index
        send(5); send(5); send(5); send(5);
        in_valid = 1'b0;
        expect_res("s3", 5, 5, 0);
        handoff();

        // Gapped stream with extremes
        send(15); in_valid = 1'b0; tick();
        send(0);  in_valid = 1'b0; tick();
        send(8);  in_valid = 1'b0;
        chk("s5_early", out_valid, 32'd0);
        tick();
        send(15); in_valid = 1'b0;
        expect_res("s5", 15, 0, 0);
        handoff();

        // Mid-frame reset discards the partial frame
        send(4); send(6);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_rst_valid", out_valid, 32'd0);
        chk("s6_rst_max",   out_max,   32'd0);
        send(4); send(6); send(2);
        in_valid = 1'b0;
        chk("s6_early", out_valid, 32'd0);
        send(1);
        in_valid = 1'b0;
        expect_res("s6", 6, 1, 1);
        handoff();

        // Randomized traffic, checked by the monitor every cycle
        repeat (600) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = WIDTH'($urandom_range(0, 15));
            out_ready = $urandom_range(0, 1) == 1;
            rst       = ($urandom_range(0, 59) == 0);
            tick();
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
